// File: rtl/data_mem_pkg.sv
// Shared definitions for the data-memory responder: MMIO register offsets,
// lane index type and the one-hot lane check used by the write decoder.
package data_mem_pkg;

  // Byte lane index within a 32-bit word
  typedef logic [1:0] lane_idx_t;

  // MMIO registers, encoded as word offsets (byte offset / 4) from MMIO_BASE
  typedef enum logic [1:0] {
    OFF_LED    = 2'd0,
    OFF_CYCLES = 2'd1,
    OFF_STORES = 2'd2,
    OFF_STATUS = 2'd3
  } mmio_off_t;

  // LED and STATUS are written through lane 0 only
  localparam lane_idx_t CTRL_LANE = 2'd0;

  // A store is legal only when exactly one lane is selected
  function automatic logic onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// Word-organised RAM built from four independent byte-lane arrays.
// Each lane has its own write enable; reads are asynchronous so the word
// at word_addr is visible in the same cycle.
module byte_lane_ram #(
  parameter int DEPTH_WORDS = 60,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    lane_we,
  input  logic [AW-1:0] word_addr,
  input  logic [7:0]    wdata,
  output logic [31:0]   rdata
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];

    // Store byte goes into this lane only when its enable is set
    always_ff @(posedge clk) begin
      if (lane_we[gi]) begin
        lane_mem[word_addr] <= wdata;
      end
    end

    assign rdata[8*gi +: 8] = lane_mem[word_addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the core's data-memory bus: byte-lane RAM plus an
// optional MMIO register window (LED, CYCLES, STORES, STATUS).
// Build option: define DATA_MEM_MMIO_EN to instantiate the MMIO window;
// without it, addresses at or above MMIO_BASE behave as unmapped space.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int         DEPTH_WORDS = 60,
  parameter logic [7:0] MMIO_BASE   = 8'hF0,
  parameter int         LED_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       access_address,
  input  logic [3:0]       byte_enable,
  input  logic             write_enable,
  input  logic [7:0]       data_write,
  output logic [31:0]      data_read,
  output logic [LED_W-1:0] led_out,
  output logic             bus_error
);

  localparam int AW        = $clog2(DEPTH_WORDS);
  localparam int RAM_BYTES = DEPTH_WORDS * 4;

  logic        is_ram;
  logic [3:0]  ram_we;
  logic [3:0]  ram_we_gated;
  logic [31:0] ram_rdata;
  logic        err_set;
  logic        bus_error_reg;
  logic        bus_error_next;
  logic        unused_addr_lsbs;

  // Bits [1:0] only say which byte the core wanted; lanes come from byte_enable
  assign unused_addr_lsbs = ^access_address[1:0];

  assign is_ram = ({24'd0, access_address} < 32'(RAM_BYTES));

  // A write landing while reset is held is dropped so no lane is half-updated
  assign ram_we_gated = ram_we & {4{reset}};

  byte_lane_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk       (clk),
    .lane_we   (ram_we_gated),
    .word_addr (access_address[AW+1:2]),
    .wdata     (data_write),
    .rdata     (ram_rdata)
  );

`ifdef DATA_MEM_MMIO_EN
  logic             is_mmio;
  mmio_off_t        mmio_off;
  logic             led_wr;
  logic             cyc_clr;
  logic             sts_clr;
  logic             store_inc;
  logic [LED_W-1:0] led_reg;
  logic [LED_W-1:0] led_next;
  logic [31:0]      cycles_reg;
  logic [31:0]      cycles_next;
  logic [31:0]      stores_reg;
  logic [31:0]      stores_next;

  assign is_mmio  = (access_address >= MMIO_BASE);
  assign mmio_off = mmio_off_t'(access_address[3:2]);
`endif

  // Classify the store: RAM lane write, MMIO side effect, or bus error
  always_comb begin
    ram_we  = 4'b0000;
    err_set = 1'b0;
`ifdef DATA_MEM_MMIO_EN
    led_wr  = 1'b0;
    cyc_clr = 1'b0;
    sts_clr = 1'b0;
`endif
    if (write_enable && (byte_enable != 4'b0000)) begin
      if (!onehot4(byte_enable)) begin
        err_set = 1'b1;
      end else if (is_ram) begin
        ram_we = byte_enable;
`ifdef DATA_MEM_MMIO_EN
      end else if (is_mmio) begin
        case (mmio_off)
          OFF_LED:    led_wr  = byte_enable[CTRL_LANE];
          OFF_CYCLES: cyc_clr = 1'b1;
          OFF_STORES: err_set = 1'b1;
          default:    sts_clr = byte_enable[CTRL_LANE] & data_write[0];
        endcase
`endif
      end else begin
        err_set = 1'b1;
      end
    end
  end

`ifdef DATA_MEM_MMIO_EN
  // Next-state for MMIO registers; CYCLES clear beats its increment
  always_comb begin
    store_inc   = (|ram_we_gated) | led_wr;
    led_next    = led_wr ? LED_W'(data_write) : led_reg;
    cycles_next = cyc_clr ? 32'd0 : cycles_reg + 32'd1;
    stores_next = (store_inc && (stores_reg != 32'hFFFF_FFFF)) ? stores_reg + 32'd1
                                                               : stores_reg;
    bus_error_next = (bus_error_reg & ~sts_clr) | err_set;
  end

  // MMIO register state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_reg    <= '0;
      cycles_reg <= 32'd0;
      stores_reg <= 32'd0;
    end else begin
      led_reg    <= led_next;
      cycles_reg <= cycles_next;
      stores_reg <= stores_next;
    end
  end

  assign led_out = led_reg;
`else
  assign bus_error_next = bus_error_reg | err_set;
  assign led_out        = '0;
`endif

  // Sticky error flag; a new error on the clearing edge keeps it set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_error_reg <= 1'b0;
    end else begin
      bus_error_reg <= bus_error_next;
    end
  end

  assign bus_error = bus_error_reg;

  // Combinational read mux; unmapped space reads as zero
  always_comb begin
    data_read = 32'h0;
    if (is_ram) begin
      data_read = ram_rdata;
`ifdef DATA_MEM_MMIO_EN
    end else if (is_mmio) begin
      case (mmio_off)
        OFF_LED:    data_read = 32'(led_reg);
        OFF_CYCLES: data_read = cycles_reg;
        OFF_STORES: data_read = stores_reg;
        default:    data_read = {31'd0, bus_error_reg};
      endcase
`endif
    end
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the processor's data-memory interface: accepts the 8-bit access address, byte-lane enables, write strobe and 8-bit store data, and returns a 32-bit read word.
- Contains a word-organised RAM with byte-lane writes, same-cycle combinational read, and a small memory-mapped register window.
- Sits between the pipelined core and the board I/O, on the core's single data bus.

Parameters:
- DEPTH_WORDS, 60, RAM words; word index = addr[7:2]; must satisfy DEPTH_WORDS*4 <= MMIO_BASE.
- MMIO_BASE, 8'hF0, first byte address of the MMIO window (16-byte aligned).
- LED_W, 8, width of the LED output register.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- access_address  input  8  byte address; [7:2] selects the word, [1:0] is informational.
- byte_enable  input  4  one-hot lane select for writes; lane k maps to bits [8k+7:8k].
- write_enable  input  1  store strobe, sampled at posedge.
- data_write  input  8  store byte, written into the enabled lane.
- data_read  output  32  read word at access_address, combinational.
- led_out  output  LED_W  MMIO LED register.
- bus_error  output  1  sticky error flag.

Behaviour:
- Reset (async, reset=0): led_out=0, bus_error=0, cycle counter=0, store counter=0. RAM contents are not cleared.
- Read:
  - data_read is valid in the same cycle as access_address, with zero cycles latency. The core samples it at the next posedge.
  - Addresses in the range DEPTH_WORDS*4 .. MMIO_BASE-1 read 32'h0.
- Write condition: a write occurs at posedge when write_enable=1 and byte_enable is exactly one-hot.
  - The enabled lane receives data_write; the other three lanes hold.
  - The new value is visible on data_read in the following cycle.
- Write enable levels: write_enable=X/0 means no write. byte_enable=0 means no write and no error.
- bus_error sets on any of the following:
  - write_enable=1 with byte_enable not one-hot and nonzero; the write is dropped.
  - write_enable=1 to the unmapped gap; the write is dropped.
  - write_enable=1 to a read-only MMIO register.
- bus_error is sticky until cleared via the STATUS register.
- MMIO window (word offsets from MMIO_BASE):
  - +0 LED: read/write. Lane 0 writes led_out[7:0]. Reads return led_out zero-extended.
  - +4 CYCLES: 32-bit free-running counter, +1 every clk, wraps 32'hFFFFFFFF -> 0. Any valid write clears it to 0 on that edge; the clear wins over the increment.
  - +8 STORES: counts completed RAM+LED writes, saturating at 32'hFFFFFFFF. Read-only; a write sets bus_error.
  - +12 STATUS: bit0 = bus_error. Writing lane 0 with data bit0=1 clears bus_error. If a new error occurs on the same edge, set wins.
- Simultaneous events: the CYCLES increment and a STORES increment on the same edge are independent.
- Reset mid-operation aborts any in-flight write; the RAM word is either fully old or fully new for that lane.

Optional Feature:
- DATA_MEM_MMIO_EN.
- Defined: MMIO window as described.
- Undefined:
  - Addresses >= MMIO_BASE behave as the unmapped gap: reads return 0, writes set bus_error.
  - led_out is tied to 0.
  - The CYCLES and STORES counters are not instantiated.

Decomposition:
- Shared package data_mem_pkg:
  - MMIO offsets (OFF_LED, OFF_CYCLES, OFF_STORES, OFF_STATUS).
  - Lane-index type.
  - Function onehot4 (valid-lane check).
- One sub-module, byte_lane_ram: DEPTH_WORDS x 32 array, four independent 8-bit write enables, async read.
- Address decode, MMIO registers and counters live in the top module.

Test Plan:
- Byte write then read:
  - Stimulus: write 8'hA5 to addr 8'h09 with byte_enable=4'b0010.
  - Next cycle, read 8'h08 -> data_read[15:8]=8'hA5, other lanes unchanged.
  - Four writes 11,22,33,44 to lanes of addr 8'h10 -> read 32'h44332211.
- Illegal lanes:
  - Stimulus: write_enable=1 with byte_enable=4'b0011 to addr 8'h04.
  - Response: RAM word unchanged, bus_error=1.
  - Then write STATUS lane 0 with 8'h01 -> bus_error=0 next cycle.
- LED and reset:
  - Stimulus: write 8'h3C to MMIO_BASE+0.
  - Response: led_out=8'h3C next cycle.
  - Assert reset asynchronously mid-cycle -> led_out=0 immediately, without waiting for a clock edge.
- Cycle counter:
  - Stimulus: after reset release, run 100 clocks, then read MMIO_BASE+4.
  - Response: data_read = 100 ±1 per the defined sampling edge.
  - Write to MMIO_BASE+4 -> reads 0 on the next cycle.
- STORES and read-only violation:
  - Stimulus: 5 legal RAM writes.
  - Response: STORES reads 5.
  - Write to MMIO_BASE+8 -> bus_error=1, STORES stays 5.
- Gap and macro-off build:
  - Stimulus: write to addr 8'hF0 (build without DATA_MEM_MMIO_EN).
  - Response: bus_error=1, read returns 0, led_out=0.
